// File: rtl/fp_pkg.sv
// Shared constants, state/class encodings and operand classifier for the FP divider.
package fp_pkg;

   localparam int unsigned FP_BIAS = 127;
   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

   // Bit positions within the {neg, zero, carry, overflow} flag vector
   localparam int unsigned NEG   = 3;
   localparam int unsigned ZERO  = 2;
   localparam int unsigned CARRY = 1;
   localparam int unsigned OVF   = 0;

   typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;
   typedef enum logic [1:0] {ClsNormal, ClsZero, ClsInf, ClsNan} cls_e;
   typedef enum logic [2:0] {SpNone, SpQnan, SpInfOvf, SpInf, SpZero} spec_e;

   // Exponent field 0 counts as zero, so denormals are flushed
   function automatic cls_e fp_classify(input logic [31:0] x);
      if (x[30:23] == 8'h00) begin
         return ClsZero;
      end else if (x[30:23] == 8'hFF) begin
         return (x[22:0] == 23'd0) ? ClsInf : ClsNan;
      end
      return ClsNormal;
   endfunction

endpackage

// File: rtl/fp_div_core.sv
// Iterative restoring divider for 24-bit mantissas: one quotient bit per step, MSB first.
module fp_div_core #(
   parameter int unsigned Iters = 26
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load_i,
   input  logic        step_i,
   input  logic [23:0] ma_i,
   input  logic [23:0] mb_i,
   output logic [25:0] q_o,
   output logic        sticky_o,
   output logic        last_o
);

   logic [24:0] r_q, r_d, r_step;
   logic [23:0] mb_q, mb_d;
   logic [25:0] q_q, q_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        ge;

   always_comb begin
      ge     = (r_q >= {1'b0, mb_q});
      r_step = ge ? (r_q - {1'b0, mb_q}) : r_q;
      r_d    = r_q;
      mb_d   = mb_q;
      q_d    = q_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         r_d   = {1'b0, ma_i};
         mb_d  = mb_i;
         q_d   = '0;
         cnt_d = '0;
      end else if (step_i) begin
         // After a successful subtract r < mb, so the shift never loses a set bit
         r_d   = r_step << 1;
         q_d   = {q_q[24:0], ge};
         cnt_d = cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q   <= '0;
         mb_q  <= '0;
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         r_q   <= r_d;
         mb_q  <= mb_d;
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign q_o      = q_q;
   assign sticky_o = |r_q;
   assign last_o   = step_i && (cnt_q == 5'(Iters - 1));

endmodule

// File: rtl/fp_div.sv
// Multi-cycle IEEE-754 single-precision divider with round-to-nearest-even and ALU-style flags.
module fp_div
   import fp_pkg::*;
#(
   parameter int unsigned LATENCY = 27
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   state_e      state_q;
   spec_e       spec_q, spec_d;
   cls_e        cls_a, cls_b;
   logic        sign_q, busy_q, done_q, accept;
   logic [9:0]  exp_q, exp_d;
   logic [31:0] result_q, res_n;
   logic [3:0]  flags_q, flg_n;
   logic [25:0] core_q;
   logic        core_rnz, core_last;

   assign accept = start && ((state_q == StIdle) || (state_q == StDone));
   assign cls_a  = fp_classify(a);
   assign cls_b  = fp_classify(b);
   assign exp_d  = 10'(a[30:23]) - 10'(b[30:23]) + 10'(FP_BIAS);

   always_comb begin
      spec_d = SpNone;
      if (cls_a == ClsNan || cls_b == ClsNan || (cls_a == ClsZero && cls_b == ClsZero) ||
          (cls_a == ClsInf && cls_b == ClsInf)) begin
         spec_d = SpQnan;
      end else if (cls_a == ClsInf) begin
         spec_d = SpInf;
      end else if (cls_b == ClsZero) begin
         spec_d = SpInfOvf;
      end else if (cls_b == ClsInf || cls_a == ClsZero) begin
         spec_d = SpZero;
      end
   end

   fp_div_core #(
      .Iters (LATENCY - 1)
   ) u_core (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (accept),
      .step_i   (state_q == StDiv),
      .ma_i     ({|a[30:23], a[22:0]}),
      .mb_i     ({|b[30:23], b[22:0]}),
      .q_o      (core_q),
      .sticky_o (core_rnz),
      .last_o   (core_last)
   );

   logic [22:0] frac, frac_r;
   logic [9:0]  e, e_r;
   logic        guard, sticky, inc, ovf, inexact;

   always_comb begin
      if (core_q[25]) begin
         frac   = core_q[24:2];
         guard  = core_q[1];
         sticky = core_q[0] | core_rnz;
         e      = exp_q;
      end else begin
         frac   = core_q[23:1];
         guard  = core_q[0];
         sticky = core_rnz;
         e      = exp_q - 10'd1;
      end
      inc = guard & (sticky | frac[0]);
      // A fraction carry-out ripples into the exponent and leaves the mantissa at 1.0
      {e_r, frac_r} = {e, frac} + {32'd0, inc};
      inexact = guard | sticky;
      ovf     = 1'b0;
      if (!e_r[9] && (e_r >= 10'd255)) begin
         res_n = {sign_q, 8'hFF, 23'd0};
         ovf   = 1'b1;
      end else if (e_r[9] || (e_r == 10'd0)) begin
         res_n = {sign_q, 31'd0};
      end else begin
         res_n = {sign_q, e_r[7:0], frac_r};
      end
      case (spec_q)
         SpQnan:   begin res_n = FP_QNAN;                 ovf = 1'b0; inexact = 1'b0; end
         SpInfOvf: begin res_n = {sign_q, 8'hFF, 23'd0};  ovf = 1'b1; inexact = 1'b0; end
         SpInf:    begin res_n = {sign_q, 8'hFF, 23'd0};  ovf = 1'b0; inexact = 1'b0; end
         SpZero:   begin res_n = {sign_q, 31'd0};         ovf = 1'b0; inexact = 1'b0; end
         default: ;
      endcase
      flg_n        = '0;
      flg_n[NEG]   = res_n[31];
      flg_n[ZERO]  = (res_n[30:0] == 31'd0);
      flg_n[CARRY] = inexact;
      flg_n[OVF]   = ovf;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         spec_q   <= SpNone;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (accept) begin
                  state_q <= StDiv;
                  busy_q  <= 1'b1;
                  sign_q  <= a[31] ^ b[31];
                  exp_q   <= exp_d;
                  spec_q  <= spec_d;
               end else begin
                  state_q <= StIdle;
               end
            end
            StDiv: begin
               if (core_last) state_q <= StNorm;
            end
            StNorm: begin
               state_q  <= StDone;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               result_q <= res_n;
               flags_q  <= flg_n;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign flags  = flags_q;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed vector table, handshake/reset sequences, random vs model.
module tb_fp_div;

   logic        clk = 1'b0;
   logic        reset_n, start;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_div dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .flags   (flags)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Exact rational quotient rounded to nearest even, then range and special rules
   function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
      logic        s;
      int          ca, cb, e;
      logic [23:0] ma, mb;
      longint unsigned num, qi, rem, mbl;
      logic [31:0] res;
      logic        inexact, ovf;
      s  = x[31] ^ y[31];
      ca = (x[30:23] == 0) ? 1 : (x[30:23] == 8'hFF) ? ((x[22:0] == 0) ? 2 : 3) : 0;
      cb = (y[30:23] == 0) ? 1 : (y[30:23] == 8'hFF) ? ((y[22:0] == 0) ? 2 : 3) : 0;
      if (ca == 3 || cb == 3 || (ca == 1 && cb == 1) || (ca == 2 && cb == 2))
         return {32'h7FC0_0000, 4'b0000};
      if (ca == 2) return {s, 8'hFF, 23'd0, s, 3'b000};
      if (cb == 1) return {s, 8'hFF, 23'd0, s, 3'b001};
      if (cb == 2 || ca == 1) return {s, 31'd0, s, 3'b100};
      ma  = {1'b1, x[22:0]};
      mb  = {1'b1, y[22:0]};
      mbl = 64'(mb);
      e   = int'(x[30:23]) - int'(y[30:23]) + 127;
      if (ma >= mb) begin
         num = 64'(ma) << 23;
      end else begin
         num = 64'(ma) << 24;
         e   = e - 1;
      end
      qi      = num / mbl;
      rem     = num % mbl;
      inexact = (rem != 0);
      if ((2 * rem > mbl) || ((2 * rem == mbl) && qi[0])) qi = qi + 1;
      if (qi == 64'h100_0000) begin
         qi = 64'h80_0000;
         e  = e + 1;
      end
      ovf = 1'b0;
      if (e >= 255) begin
         res = {s, 8'hFF, 23'd0};
         ovf = 1'b1;
      end else if (e <= 0) begin
         res = {s, 31'd0};
      end else begin
         res = {s, 8'(e), qi[22:0]};
      end
      return {res, res[31], (res[30:0] == 0), inexact, ovf};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] x;
      x = $urandom;
      case ($urandom_range(0, 15))
         0: x[30:23] = 8'h00;
         1: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
         2: begin x[30:23] = 8'hFF; x[22] = 1'b1; end
         3: ;
         4: begin x[30:23] = 8'($urandom_range(120, 134)); x[15:0] = 16'd0; end
         5: x[30:23] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 3))
                                                   : 8'($urandom_range(252, 254));
         default: x[30:23] = 8'($urandom_range(100, 154));
      endcase
      return x;
   endfunction

   // Starts a divide (accepted even during a done cycle); lat = edges until done, capped at 40
   task automatic run_div(input logic [31:0] av, input logic [31:0] bv, output logic [31:0] r,
                          output logic [3:0] f, output int lat, output logic busy_ok);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      a       = $urandom;
      b       = $urandom;
      lat     = 0;
      busy_ok = 1'b1;
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      if (busy) busy_ok = 1'b0;
      r = result;
      f = flags;
   endtask

   vec_t        vecs[9];
   logic [31:0] r;
   logic [3:0]  f;
   logic [35:0] expv;
   int          lat, ndone, first_lat;
   logic        bok;
   logic [31:0] first_res;

   initial begin
      vecs[0] = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000};
      vecs[1] = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0010};
      vecs[2] = '{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'b1000};
      vecs[3] = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b1001};
      vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0000};
      vecs[5] = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000};
      vecs[6] = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b0001};
      vecs[7] = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0100};
      vecs[8] = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 4'b0100};

      reset_n = 1'b0;
      start   = 1'b0;
      a       = '0;
      b       = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", result, 32'd0);
      check("reset flags", 32'(flags), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_div(vecs[i].a, vecs[i].b, r, f, lat, bok);
         check($sformatf("vec%0d result", i), r, vecs[i].res);
         check($sformatf("vec%0d flags", i), 32'(f), 32'(vecs[i].flg));
         check($sformatf("vec%0d latency", i), 32'(lat), 32'd27);
         check($sformatf("vec%0d busy", i), 32'(bok), 32'd1);
      end

      // Back-to-back: second start issued while done is high
      run_div(32'h40C0_0000, 32'h4000_0000, r, f, lat, bok);
      check("b2b done seen", 32'(done), 32'd1);
      run_div(32'h3F80_0000, 32'h4040_0000, r, f, lat, bok);
      check("b2b latency", 32'(lat), 32'd27);
      check("b2b result", r, 32'h3EAA_AAAB);

      // A start pulse five cycles into a busy divide must be ignored
      @(negedge clk);
      a     = 32'h40C0_0000;
      b     = 32'h4000_0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      ndone     = 0;
      first_lat = 0;
      first_res = '0;
      for (int i = 1; i <= 60; i++) begin
         if (i == 5) begin
            @(negedge clk);
            a     = 32'h3F80_0000;
            b     = 32'h4040_0000;
            start = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               first_lat = i;
               first_res = result;
            end
         end
      end
      check("ignored start done count", 32'(ndone), 32'd1);
      check("ignored start latency", 32'(first_lat), 32'd27);
      check("ignored start result", first_res, 32'h4040_0000);

      // Reset mid-divide aborts it
      @(negedge clk);
      a     = 32'h3F80_0000;
      b     = 32'h4040_0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset done", 32'(done), 32'd0);
      check("midreset result", result, 32'd0);
      check("midreset flags", 32'(flags), 32'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (i == 2) reset_n = 1'b1;
         if (done) ndone++;
      end
      check("midreset no done", 32'(ndone), 32'd0);
      run_div(32'h40C0_0000, 32'h4000_0000, r, f, lat, bok);
      check("post reset result", r, 32'h4040_0000);
      check("post reset flags", 32'(f), 32'd0);
      check("post reset latency", 32'(lat), 32'd27);

      for (int i = 0; i < 150; i++) begin
         logic [31:0] ra, rb;
         ra   = rand_op();
         rb   = rand_op();
         expv = model(ra, rb);
         run_div(ra, rb, r, f, lat, bok);
         check($sformatf("rand%0d %h/%h result", i, ra, rb), r, expv[35:4]);
         check($sformatf("rand%0d %h/%h flags", i, ra, rb), 32'(f), 32'(expv[3:0]));
         check($sformatf("rand%0d latency", i), 32'(lat), 32'd27);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
